dac_spi_writer: RTL and testbench
=================================

# dac_spi_writer

Downstream output stage for the 12-bit filtered sample stream from the convolution filter. It takes each new `outSample` value and its ready strobe, then serialises the value as a 16-bit write frame to an MCP4921-class SPI DAC. After each frame it pulses LDAC so the analogue output updates exactly once per sample. It holds one pending sample while a frame is in flight and reports any overwritten sample.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `inClock` cycles. Must be ≥1.
- `DAC_CONFIG`, default 4'b0111: frame bits [15:12] (A/B=0, BUF=1, GA_n=1, SHDN_n=1).

Ports:
- `inClock` input 1: system clock. One clock domain; all logic runs on its rising edge.
- `inReset` input 1: reset, asynchronous and active-high.
- `inSample` input 12: sample from the filter. Must be stable from the `inSampleReady` rising edge for ≥4 `inClock` cycles.
- `inSampleReady` input 1: sample strobe. It is not synchronous to `inClock`; only its rising edge is significant.
- `outCsN` output 1: DAC chip select, active low.
- `outSclk` output 1: SPI clock. Idles low; the DAC samples on the rising edge.
- `outMosi` output 1: serial data, MSB first.
- `outLdacN` output 1: DAC latch strobe, active low.
- `outBusy` output 1: high whenever the FSM is not in IDLE.
- `outDropped` output 1: one-cycle pulse when an unsent pending sample is overwritten.

## Operation
- `inSampleReady` passes through a 2-FF synchroniser, then a rising-edge detector. The result is an internal one-cycle `edge` pulse.
- On `edge`:
  - `inSample` is latched into `pending` and `pendingValid` is set.
  - If `pendingValid` was already set and not consumed in that same cycle, `outDropped` pulses.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC.
- Transitions:
  - IDLE → CS_SETUP when `pendingValid`. The shift register loads {DAC_CONFIG, pending} and `pendingValid` clears.
  - CS_SETUP: CLK_DIV cycles; `outCsN`=0, `outSclk`=0, `outMosi`=bit15.
  - SHIFT: 16 bits. Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
    - `outMosi` changes only at the start of a low phase, i.e. on the SCLK falling edge.
    - Bit counter is 4 bits and counts 15 down to 0.
  - SHIFT → CS_HOLD after the high phase of bit 0. CS_HOLD lasts CLK_DIV cycles: SCLK=0, CS still low.
  - LDAC: `outCsN`=1 and `outLdacN`=0 for CLK_DIV cycles.
  - From the last LDAC cycle: go to CS_SETUP if `pendingValid` (load as above), else go to IDLE.
- Frame length is exactly 35·CLK_DIV cycles from CS falling to LDAC rising (140 at default).
- Phase counter width is $clog2(CLK_DIV)+1. It reloads on every phase change.

## Timing
- Reset (asynchronous) forces:
  - `outCsN`=1, `outSclk`=0, `outMosi`=0, `outLdacN`=1, `outBusy`=0, `outDropped`=0.
  - State=IDLE, `pendingValid`=0, synchroniser FFs=0.
- Reset mid-frame aborts the frame: CS rises immediately and no LDAC pulse is issued.
- Latency from the `inSampleReady` rising edge to `edge` is 2–3 `inClock` cycles.
- From `edge` in IDLE, `outCsN` falls and `outBusy` rises on the next cycle.
- Back-to-back frames: `outLdacN` rises and `outCsN` falls on the same clock edge, with no IDLE cycle in between.
- Simultaneous events:
  - `edge` during the final LDAC cycle while `pendingValid`=0: the sample is stored and sent in the next frame, with no drop.
  - `edge` in the same cycle that `pending` is consumed: the new sample wins `pending`, with no drop.
  - `edge` while `pendingValid`=1 and no consume: overwrite, and `outDropped`=1 for exactly one cycle.
- SCLK duty cycle is exactly 50%. CS setup and hold are each CLK_DIV cycles.

## Structure
- Shared package `synth_audio_pkg`:
  - `SAMPLE_W`=12.
  - `DAC_FRAME_W`=16.
  - `DAC_CFG_MCP4921`=4'b0111.
  - The `dac_state_t` enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC).
- Sub-module `sync_edge_detect`: 2-FF synchroniser plus rising-edge pulse, with async active-high reset. It is reusable for the other strobes in the synth.
- Remaining logic stays in `dac_spi_writer`: FSM, phase/bit counters, shift register, pending register.

## Test plan
- Reset release, then one strobe with `inSample`=12'hA5C, CLK_DIV=4:
  - The bus captures frame 16'h7A5C.
  - CS is low for 136 cycles, followed by a 4-cycle LDAC low.
  - Bits are sampled on 16 SCLK rising edges.
- Three strobes 10 cycles apart with values 12'h001, 12'h002, 12'h003 during frame 1:
  - Frames sent are 0x7001, then 0x7003.
  - `outDropped` pulses once, on the third strobe.
- Strobe timed so `edge` lands on the final LDAC cycle with value 12'hFFF:
  - The next frame 0x7FFF starts on the following edge.
  - No IDLE cycle occurs and `outDropped` stays 0.
- Assert `inReset` during SHIFT bit 7:
  - All outputs return to reset values asynchronously, and no LDAC pulse occurs.
  - A new strobe with value 12'h800 after reset sends 0x7800 cleanly.
- CLK_DIV=1 with value 12'h000:
  - Frame is 0x7000 and lasts 35 cycles.
  - SCLK toggles every cycle and `outBusy` is high for exactly 35 cycles.

Source files
------------

// File: rtl/synth_audio_pkg.sv
// Shared types and constants for the synth audio output path.
package synth_audio_pkg;

    localparam int SAMPLE_W    = 12;
    localparam int DAC_FRAME_W = 16;

    // MCP4921 command nibble: A/B=0, BUF=1, GA_n=1, SHDN_n=1
    localparam logic [3:0] DAC_CFG_MCP4921 = 4'b0111;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        LDAC
    } dac_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a
// one-cycle pulse in the inClock domain for each rising edge of inAsync.
module sync_edge_detect (
    input  logic inClock,
    input  logic inReset,
    input  logic inAsync,
    output logic outPulse
);

    // [0],[1] form the synchroniser; [2] holds the previous synchronised level
    logic [2:0] syncReg;

    // Shift the asynchronous level through the synchroniser chain
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[1:0], inAsync};
        end
    end

    assign outPulse = syncReg[1] & ~syncReg[2];

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises each 12-bit filtered sample into a 16-bit MCP4921 write frame
// and pulses LDAC once per frame. One sample can wait while a frame is in
// flight; overwriting an unsent sample raises outDropped for one cycle.
module dac_spi_writer
    import synth_audio_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [3:0] DAC_CONFIG = DAC_CFG_MCP4921
) (
    input  logic                inClock,
    input  logic                inReset,
    input  logic [SAMPLE_W-1:0] inSample,
    input  logic                inSampleReady,
    output logic                outCsN,
    output logic                outSclk,
    output logic                outMosi,
    output logic                outLdacN,
    output logic                outBusy,
    output logic                outDropped
);

    localparam int              PH_W    = $clog2(CLK_DIV) + 1;
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(CLK_DIV - 1);

    dac_state_t             state;
    dac_state_t             stateNext;
    logic                   edgePulse;
    logic                   startFrame;
    logic [PH_W-1:0]        phaseCnt;
    logic                   phaseDone;
    logic                   sclkHigh;
    logic [3:0]             bitCnt;
    logic [DAC_FRAME_W-1:0] shiftReg;
    logic [SAMPLE_W-1:0]    pending;
    logic                   pendingValid;

    sync_edge_detect readySync (
        .inClock (inClock),
        .inReset (inReset),
        .inAsync (inSampleReady),
        .outPulse(edgePulse)
    );

    assign phaseDone = (phaseCnt == '0);

    // State register
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and bus outputs; a sample arriving on the cycle a frame
    // may start is taken immediately so no idle gap appears between frames
    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        outCsN     = 1'b1;
        outSclk    = 1'b0;
        outMosi    = 1'b0;
        outLdacN   = 1'b1;
        outBusy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (pendingValid || edgePulse) begin
                    stateNext  = CS_SETUP;
                    startFrame = 1'b1;
                end
            end
            CS_SETUP: begin
                outCsN  = 1'b0;
                outMosi = shiftReg[DAC_FRAME_W-1];
                if (phaseDone) stateNext = SHIFT;
            end
            SHIFT: begin
                outCsN  = 1'b0;
                outSclk = sclkHigh;
                outMosi = shiftReg[DAC_FRAME_W-1];
                if (phaseDone && sclkHigh && (bitCnt == 4'd0)) stateNext = CS_HOLD;
            end
            CS_HOLD: begin
                outCsN  = 1'b0;
                outMosi = shiftReg[DAC_FRAME_W-1];
                if (phaseDone) stateNext = LDAC;
            end
            LDAC: begin
                outLdacN = 1'b0;
                if (phaseDone) begin
                    if (pendingValid || edgePulse) begin
                        stateNext  = CS_SETUP;
                        startFrame = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Pending slot: the older pending sample is sent first, a coincident new
    // sample then takes its place; only an unconsumed overwrite is a drop
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            pending      <= '0;
            pendingValid <= 1'b0;
            outDropped   <= 1'b0;
        end else begin
            outDropped <= edgePulse && pendingValid && !startFrame;
            if (edgePulse) pending <= inSample;
            if (startFrame) begin
                pendingValid <= edgePulse && pendingValid;
            end else if (edgePulse) begin
                pendingValid <= 1'b1;
            end
        end
    end

    // Phase timing, SCLK phase, bit counter and shift register
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            phaseCnt <= '0;
            sclkHigh <= 1'b0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (startFrame) begin
            phaseCnt <= PH_LOAD;
            sclkHigh <= 1'b0;
            bitCnt   <= 4'd15;
            shiftReg <= {DAC_CONFIG, (pendingValid ? pending : inSample)};
        end else begin
            if ((state != stateNext) || ((state == SHIFT) && phaseDone)) begin
                phaseCnt <= PH_LOAD;
            end else if (!phaseDone) begin
                phaseCnt <= phaseCnt - PH_W'(1);
            end
            if ((state == SHIFT) && phaseDone) begin
                if (!sclkHigh) begin
                    sclkHigh <= 1'b1;
                end else begin
                    sclkHigh <= 1'b0;
                    if (bitCnt != 4'd0) begin
                        bitCnt   <= bitCnt - 4'd1;
                        shiftReg <= {shiftReg[DAC_FRAME_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Scoreboard bench for dac_spi_writer: two instances (CLK_DIV=4 and 1).
// Stimulus pushes expected frames; bus monitors decode frames and compare.
module tb_dac_spi_writer;

    logic        clk = 1'b0;
    logic        rstA, rstB;
    logic [11:0] sampA, sampB;
    logic        rdyA, rdyB;
    logic        csA, sclkA, mosiA, ldA, busyA, dropA;
    logic        csB, sclkB, mosiB, ldB, busyB, dropB;

    logic [15:0] qA[$];
    logic [15:0] qB[$];

    int checks = 0;
    int fails  = 0;
    int ldacPulsesA = 0, expLdA = 0, dropPulsesA = 0;
    int ldacPulsesB = 0, expLdB = 0, dropPulsesB = 0;

    always #5 clk = ~clk;

    dac_spi_writer #(.CLK_DIV(4), .DAC_CONFIG(4'b0111)) dutA (
        .inClock(clk), .inReset(rstA), .inSample(sampA), .inSampleReady(rdyA),
        .outCsN(csA), .outSclk(sclkA), .outMosi(mosiA), .outLdacN(ldA),
        .outBusy(busyA), .outDropped(dropA)
    );

    dac_spi_writer #(.CLK_DIV(1), .DAC_CONFIG(4'b0111)) dutB (
        .inClock(clk), .inReset(rstB), .inSample(sampB), .inSampleReady(rdyB),
        .outCsN(csB), .outSclk(sclkB), .outMosi(mosiB), .outLdacN(ldB),
        .outBusy(busyB), .outDropped(dropB)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResetA(input string tag);
        check({tag, " csN"},   csA,   1);
        check({tag, " sclk"},  sclkA, 0);
        check({tag, " mosi"},  mosiA, 0);
        check({tag, " ldacN"}, ldA,   1);
        check({tag, " busy"},  busyA, 0);
        check({tag, " drop"},  dropA, 0);
    endtask

    // Expected frame is simply the command nibble over the 12-bit sample
    function automatic logic [15:0] frameOf(input logic [11:0] v);
        return {4'b0111, v};
    endfunction

    task automatic strobeA(input logic [11:0] v);
        @(posedge clk); #1;
        sampA = v; rdyA = 1'b1;
        repeat (5) @(posedge clk);
        #1 rdyA = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic strobeB(input logic [11:0] v);
        @(posedge clk); #1;
        sampB = v; rdyB = 1'b1;
        repeat (5) @(posedge clk);
        #1 rdyB = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic waitIdleA(input int maxc);
        int n = 0;
        do begin @(negedge clk); n++; end while (busyA && n < maxc);
        check("A idle within budget", busyA, 0);
    endtask

    task automatic waitIdleB(input int maxc);
        int n = 0;
        do begin @(negedge clk); n++; end while (busyB && n < maxc);
        check("B idle within budget", busyB, 0);
    endtask

    // Monitor A: decodes frames on SCLK rises, checks CS/LDAC widths
    initial begin
        int bits = 0, csLow = 0, ldLow = 0, dropRun = 0;
        logic [15:0] acc = '0;
        logic [15:0] exp;
        logic pSclk = 1'b0, pCs = 1'b1, pLd = 1'b1, pDrop = 1'b0;
        forever begin
            @(negedge clk);
            if (rstA) begin
                bits = 0; csLow = 0; ldLow = 0; dropRun = 0; acc = '0;
            end else begin
                if (!csA) csLow++;
                if (!csA && sclkA && !pSclk) begin
                    acc = {acc[14:0], mosiA};
                    bits++;
                end
                if (csA && !pCs) begin
                    if (qA.size() == 0) begin
                        check("A unexpected frame", acc, 32'hFFFF_FFFF);
                    end else begin
                        exp = qA.pop_front();
                        check("A frame", acc, exp);
                    end
                    check("A bit count", bits, 16);
                    check("A cs low cycles", csLow, 136);
                    bits = 0; csLow = 0; acc = '0;
                end
                if (!ldA) ldLow++;
                if (ldA && !pLd) begin
                    check("A ldac low cycles", ldLow, 4);
                    ldLow = 0;
                    ldacPulsesA++;
                end
                if (dropA) dropRun++;
                if (!dropA && pDrop) begin
                    check("A drop pulse width", dropRun, 1);
                    dropRun = 0;
                    dropPulsesA++;
                end
            end
            pSclk = sclkA; pCs = csA; pLd = ldA; pDrop = dropA;
        end
    end

    // Monitor B: CLK_DIV=1, frame spans 35 busy cycles with SCLK toggling each cycle
    initial begin
        int bits = 0, busyCnt = 0, toggles = 0;
        logic [15:0] acc = '0;
        logic [15:0] exp;
        logic pSclk = 1'b0, pBusy = 1'b0, pLd = 1'b1;
        forever begin
            @(negedge clk);
            if (rstB) begin
                bits = 0; busyCnt = 0; toggles = 0; acc = '0;
            end else begin
                if (busyB) busyCnt++;
                if (busyB && (sclkB != pSclk)) toggles++;
                if (!csB && sclkB && !pSclk) begin
                    acc = {acc[14:0], mosiB};
                    bits++;
                end
                if (!ldB && pLd) ldacPulsesB++;
                if (dropB) dropPulsesB++;
                if (!busyB && pBusy) begin
                    if (qB.size() == 0) begin
                        check("B unexpected frame", acc, 32'hFFFF_FFFF);
                    end else begin
                        exp = qB.pop_front();
                        check("B frame", acc, exp);
                    end
                    check("B bit count", bits, 16);
                    check("B busy cycles", busyCnt, 35);
                    check("B sclk toggles", toggles, 32);
                    bits = 0; busyCnt = 0; toggles = 0; acc = '0;
                end
            end
            pSclk = sclkB; pBusy = busyB; pLd = ldB;
        end
    end

    // Stimulus
    initial begin
        logic [11:0] v;
        int n;
        int rises;
        logic pS;
        rstA = 1'b1; rstB = 1'b1;
        rdyA = 1'b0; rdyB = 1'b0;
        sampA = '0; sampB = '0;
        #2;
        checkResetA("reset");
        check("B reset csN", csB, 1);
        check("B reset busy", busyB, 0);
        repeat (3) @(posedge clk);
        #1 rstA = 1'b0; rstB = 1'b0;

        // Single frame
        qA.push_back(frameOf(12'hA5C)); expLdA++;
        strobeA(12'hA5C);
        waitIdleA(400);

        // Three strobes during one frame: middle one is overwritten
        qA.push_back(frameOf(12'h001));
        qA.push_back(frameOf(12'h003));
        expLdA += 2;
        strobeA(12'h001);
        strobeA(12'h002);
        strobeA(12'h003);
        waitIdleA(800);
        check("A drops after burst", dropPulsesA, 1);

        // Sample edge on the final LDAC cycle starts the next frame back-to-back
        v = 12'($urandom);
        qA.push_back(frameOf(v)); expLdA++;
        strobeA(v);
        n = 0;
        do begin @(negedge clk); n++; end while (ldA && n < 400);
        check("A ldac seen", ldA, 0);
        @(posedge clk); #1;
        sampA = 12'hFFF; rdyA = 1'b1;
        qA.push_back(frameOf(12'hFFF)); expLdA++;
        n = 0;
        do begin @(negedge clk); n++; end while (!ldA && n < 20);
        check("A b2b csN low at ldac rise", csA, 0);
        check("A b2b busy held", busyA, 1);
        repeat (3) @(posedge clk);
        #1 rdyA = 1'b0;
        waitIdleA(400);
        check("A no drop on final-ldac edge", dropPulsesA, 1);

        // Reset during SHIFT bit 7 aborts the frame
        v = 12'($urandom);
        fork
            strobeA(v);
        join_none
        rises = 0; pS = 1'b0; n = 0;
        while (rises < 8 && n < 400) begin
            @(negedge clk); n++;
            if (sclkA && !pS) rises++;
            pS = sclkA;
        end
        check("A reached bit 7", rises, 8);
        n = 0;
        while (sclkA && n < 20) begin @(negedge clk); n++; end
        #2 rstA = 1'b1;
        #1 checkResetA("async reset mid-frame");
        repeat (3) @(posedge clk);
        #1 rstA = 1'b0;
        qA.push_back(frameOf(12'h800)); expLdA++;
        strobeA(12'h800);
        waitIdleA(400);

        // Random well-spaced samples
        for (int i = 0; i < 5; i++) begin
            v = 12'($urandom);
            qA.push_back(frameOf(v)); expLdA++;
            strobeA(v);
            waitIdleA(400);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end

        // CLK_DIV=1 instance
        qB.push_back(frameOf(12'h000)); expLdB++;
        strobeB(12'h000);
        waitIdleB(100);
        for (int i = 0; i < 3; i++) begin
            v = 12'($urandom);
            qB.push_back(frameOf(v)); expLdB++;
            strobeB(v);
            waitIdleB(100);
        end

        repeat (5) @(negedge clk);
        check("A all frames seen", qA.size(), 0);
        check("B all frames seen", qB.size(), 0);
        check("A ldac pulse count", ldacPulsesA, expLdA);
        check("A total drops", dropPulsesA, 1);
        check("B ldac pulse count", ldacPulsesB, expLdB);
        check("B total drops", dropPulsesB, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
